// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe - handshaked, parametrised ALU stage between operand/decode and
// writeback.
//
// An operation is accepted on a valid/ready input port. Every operation
// except MUL completes in one cycle. MUL is an iterative shift-add multiply
// that takes WIDTH cycles. The result and flags are registered and held on a
// valid/ready output port until the consumer takes them.
//
// Build option:
//   ALU_MUL_EN - when defined, opcode 11 is the iterative unsigned multiply
//                and a BUSY state is present. When undefined, opcode 11 is an
//                illegal opcode and result_hi is always 0.
//
// Parameters:
//   WIDTH      - operand and result width in bits (must be >= 2).
//
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   in_valid, in_ready   - input handshake; a/b/op are sampled on accept
//   a, b, op             - operands (b is also the shift amount) and opcode
//   out_valid, out_ready - output handshake
//   result, result_hi    - result (low half for MUL) and MUL high half
//   carry, zero, negative, overflow, illegal - status flags
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             illegal
);

    typedef logic [WIDTH-1:0] word_t;
    localparam word_t WIDTH_W = word_t'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_PASS = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam int         CW      = $clog2(WIDTH + 1);
    typedef logic [CW-1:0] count_t;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MUL_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic           out_valid_r;
    word_t          result_r;
    word_t          result_hi_r;
    logic           carry_r;
    logic           zero_r;
    logic           negative_r;
    logic           overflow_r;
    logic           illegal_r;

    logic           in_ready_s;
    logic           accept_s;
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;
    logic           shift_big_s;
    word_t          alu_res_s;
    logic           alu_carry_s;
    logic           alu_ovf_s;
    logic           alu_ill_s;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    word_t              mplier_r;
    count_t             count_r;
    logic [2*WIDTH-1:0] acc_next_s;
`endif

    // Single-cycle ALU: result, carry/borrow, signed overflow and illegal-op detect
    always_comb begin
        sum_s       = {1'b0, a} + {1'b0, b};
        diff_s      = {1'b0, a} - {1'b0, b};
        shift_big_s = (b >= WIDTH_W);
        alu_res_s   = '0;
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        alu_ill_s   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s[WIDTH-1:0];
                alu_carry_s = diff_s[WIDTH];    // borrow out == unsigned a < b
                alu_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH]};
            OP_PASS: alu_res_s = a;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SHL:  alu_res_s = shift_big_s ? '0 : (a << b);
            OP_SHR:  alu_res_s = shift_big_s ? '0 : (a >> b);
            OP_SRA:  alu_res_s = shift_big_s ? {WIDTH{a[WIDTH-1]}} : word_t'($signed(a) >>> b);
`ifdef ALU_MUL_EN
            OP_MUL:  alu_res_s = '0;    // produced by the iterative path
`endif
            default: alu_ill_s = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    // Shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end
`endif

    // Input ready: only from state and out_ready, never from in_valid
    always_comb begin
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                DONE:    in_ready_s = out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = in_valid & in_ready_s;

    // Control FSM with registered result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            result_hi_r <= '0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            negative_r  <= 1'b0;
            overflow_r  <= 1'b0;
            illegal_r   <= 1'b0;
`ifdef ALU_MUL_EN
            acc_r       <= '0;
            mcand_r     <= '0;
            mplier_r    <= '0;
            count_r     <= '0;
`endif
        end else if (accept_s) begin
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
                acc_r       <= '0;
                mcand_r     <= {{WIDTH{1'b0}}, a};
                mplier_r    <= b;
                count_r     <= count_t'(WIDTH);
                state_r     <= BUSY;
                out_valid_r <= 1'b0;
            end else
`endif
            begin
                result_r    <= alu_res_s;
                result_hi_r <= '0;
                carry_r     <= alu_carry_s;
                zero_r      <= (alu_res_s == '0) && !alu_ill_s;
                negative_r  <= alu_res_s[WIDTH-1];
                overflow_r  <= alu_ovf_s;
                illegal_r   <= alu_ill_s;
                state_r     <= DONE;
                out_valid_r <= 1'b1;
            end
        end else begin
            case (state_r)
`ifdef ALU_MUL_EN
                BUSY: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r - count_t'(1);
                    // Last step: the accumulator now holds the full product
                    if (count_r == count_t'(1)) begin
                        result_r    <= acc_next_s[WIDTH-1:0];
                        result_hi_r <= acc_next_s[2*WIDTH-1:WIDTH];
                        carry_r     <= |acc_next_s[2*WIDTH-1:WIDTH];
                        zero_r      <= (acc_next_s[WIDTH-1:0] == '0);
                        negative_r  <= acc_next_s[WIDTH-1];
                        overflow_r  <= 1'b0;
                        illegal_r   <= 1'b0;
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    // Consumed with nothing new offered: drop valid, keep last result
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                IDLE: begin
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign negative  = negative_r;
    assign overflow  = overflow_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe - scoreboard bench for alu_pipe (WIDTH=8).
// The stimulus pushes the hand-computed expected response when an operation is
// accepted. The monitor pops and compares whenever a result is consumed.
// ---------------------------------------------------------------------------
module tb_alu_pipe;
    localparam int W = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_PASS = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;
    logic         illegal;

    // {illegal, overflow, negative, zero, carry, result_hi, result}
    typedef logic [2*W+4:0] resp_t;

    resp_t exp_q[$];
    int    pop_cyc[$];
    int    cyc = 0;
    int    acc_cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    // Cycle counter used to time outputs against accepting edges
    always @(posedge clk) cyc <= cyc + 1;

    function automatic resp_t mk(input logic [W-1:0] res, input logic [W-1:0] hi,
                                 input logic c, input logic z, input logic n,
                                 input logic v, input logic i);
        return {i, v, n, z, c, hi, res};
    endfunction

    // Monitor: every consumed result is compared against the scoreboard head
    always @(negedge clk) begin
        resp_t act;
        resp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            act = {illegal, overflow, negative, zero, carry, result_hi, result};
            pop_cyc.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h, none expected", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL result_check: got %h, expected %h", act, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one op; record its accept edge and (optionally) its expected response
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input resp_t e, input bit push);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc_cyc = cyc + 1;
                if (push) exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: op %0d never accepted", o);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick(1);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst = 1'b1;
        in_valid = 1'b1;
        op = OP_ADD;
        a = 8'h12;
        b = 8'h34;
        out_ready = 1'b1;

        // Reset: two cycles with an op offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {illegal, overflow, negative, zero, carry, result_hi, result}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        tick(1);

        // ADD wrap with carry; visible right after the accepting edge
        pop_cyc.delete();
        send(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        tick(2);
        check("add_latency", (pop_cyc.size() > 0) ? (pop_cyc[0] - acc_cyc) : -1, 0);

        // SUB signed overflow
        send(OP_SUB, 8'h80, 8'h01, mk(8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
        tick(2);

        // Back-to-back stream, one op per cycle
        pop_cyc.delete();
        send(OP_AND, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SLT, 8'hFF, 8'h01, mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SRA, 8'h80, 8'h09, mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
        tick(3);
        check("stream_count", pop_cyc.size(), 3);
        check("stream_no_bubble", (pop_cyc.size() == 3) ? (pop_cyc[2] - pop_cyc[0]) : -1, 2);

        // Backpressure: result held, next op refused until out_ready
        out_ready = 1'b0;
        send(OP_ADD, 8'h03, 8'h04, mk(8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        in_valid = 1'b1;
        op = OP_OR;
        a = 8'h01;
        b = 8'h02;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 8'h07);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(OP_OR, 8'h01, 8'h02, mk(8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        tick(2);

        // Directed vectors incl. shift boundaries
        send(OP_OR,   8'h0F, 8'hA0, mk(8'hAF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
        send(OP_XOR,  8'hFF, 8'hFF, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SLTU, 8'h01, 8'hFF, mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SLTU, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_PASS, 8'h80, 8'h33, mk(8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
        send(OP_SLT,  8'h01, 8'hFF, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SHL,  8'h81, 8'h01, mk(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SHL,  8'hFF, 8'h08, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SHR,  8'h80, 8'h07, mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SHR,  8'hFF, 8'hFF, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SRA,  8'h40, 8'h03, mk(8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_SRA,  8'h7F, 8'h08, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        send(OP_ADD,  8'h7F, 8'h01, mk(8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
        send(OP_SUB,  8'h00, 8'h01, mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
        send(OP_SUB,  8'h05, 8'h05, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        send(4'd13,   8'h5A, 8'h33, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        send(4'd15,   8'hFF, 8'hFF, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        drain();
        tick(2);

`ifdef ALU_MUL_EN
        // Iterative multiply: result WIDTH cycles after the accepting edge
        pop_cyc.delete();
        send(OP_MUL, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        check("mul_busy_in_ready", in_ready, 0);
        check("mul_busy_out_valid", out_valid, 0);
        drain();
        check("mul_latency", (pop_cyc.size() > 0) ? (pop_cyc[0] - acc_cyc) : -1, 8);
        tick(2);

        // Reset in the 4th BUSY cycle aborts the multiply
        send(OP_MUL, 8'h03, 8'h05, '0, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("mul_abort_out_valid", out_valid, 0);
        check("mul_abort_result", result, 0);
        check("mul_abort_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("mul_abort_no_valid", seen, 0);
        tick(1);
        send(OP_ADD, 8'h01, 8'h01, mk(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        drain();
`else
        // Without the multiplier, opcode 11 is a 1-cycle illegal op
        pop_cyc.delete();
        send(OP_MUL, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        drain();
        check("mul_off_latency", (pop_cyc.size() > 0) ? (pop_cyc[0] - acc_cyc) : -1, 0);
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
